slot_reel_engine: RTL

Parametrised N-reel slot-machine spin engine: replaces the single-mode three-digit spinner with a generic engine driving NUM_REELS decimal reels from one system clock. Holding start ramps reel speed up; releasing ramps it down, then stops the reels left to right with a programmable stagger. The final symbols are evaluated for a full match (jackpot) or an adjacent pair. Sits between the debounced start button and the seven-segment and score logic.

---
 rtl/slot_pkg.sv | 26 ++
 rtl/slot_reel.sv | 49 ++++
 rtl/slot_reel_engine.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot reel engine: FSM states, LFSR
// parameters and small BCD helpers.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPIN_UP,
        SPIN_DOWN,
        STOPPING,
        EVAL
    } slot_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  BCD_MAX   = 4'd9;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] bcd_mod10(input logic [3:0] n);
        return (n > BCD_MAX) ? n - 4'd10 : n;
    endfunction

endpackage

// File: rtl/slot_reel.sv
// One decimal reel: speed accumulator, digit advance with 9->0 wrap and the
// stopped flag. Seeding overrides everything else in the same cycle.
module slot_reel
    import slot_pkg::*;
#(
    parameter int MAX_SPEED = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seed,
    input  logic [3:0] seed_digit,
    input  logic       tick,
    input  logic [7:0] speed,
    input  logic       stop,
    input  logic       clr_stop,
    output logic [3:0] digit,
    output logic       stopped
);
    logic [7:0] acc;
    logic [8:0] acc_sum;
    logic       wrap;

    // Nine bits so acc + speed cannot overflow before the MAX_SPEED compare
    assign acc_sum = {1'b0, acc} + {1'b0, speed};
    assign wrap    = (acc_sum >= 9'(MAX_SPEED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit   <= '0;
            acc     <= '0;
            stopped <= 1'b1;
        end else if (seed) begin
            digit   <= seed_digit;
            acc     <= '0;
            stopped <= 1'b0;
        end else begin
            if (tick && !stopped) begin
                acc <= wrap ? 8'(acc_sum - 9'(MAX_SPEED)) : acc_sum[7:0];
                if (wrap)
                    digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
            end
            if (clr_stop)
                stopped <= 1'b0;
            else if (stop)
                stopped <= 1'b1;
        end
    end

endmodule

// File: rtl/slot_reel_engine.sv
// N-reel slot spin engine: start synchroniser, free-running LFSR, frame divider,
// spin FSM and result evaluation around an array of slot_reel instances.
module slot_reel_engine
    import slot_pkg::*;
#(
    parameter int NUM_REELS = 3,
    parameter int FRAME_DIV = 50000,
    parameter int MAX_SPEED = 15,
    parameter int STAGGER   = 8,
    parameter int WINCNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [4*NUM_REELS-1:0] digits,
    output logic [NUM_REELS-1:0]   stopped,
    output logic [7:0]             speed,
    output logic                   pause,
    output logic                   won,
    output logic                   pair,
    output logic [WINCNT_W-1:0]    win_cnt
);
    localparam int FD_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SC_W = 16;

    slot_state_e               state, state_nxt;
    logic                      start_meta, start_s, start_d, start_rise;
    logic [15:0]               lfsr;
    logic [FD_W-1:0]           fcnt;
    logic                      tick, enter_stop;
    logic [SC_W-1:0]           scnt, scnt_inc;
    logic [NUM_REELS-1:0]      stop_req;
    logic [NUM_REELS-1:0][3:0] dig;
    logic                      seed, clr_stop, spd_inc, spd_dec, do_eval;
    logic                      all_eq, any_pair;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_meta <= 1'b0;
            start_s    <= 1'b0;
            start_d    <= 1'b0;
            lfsr       <= LFSR_SEED;
        end else begin
            start_meta <= start;
            start_s    <= start_meta;
            start_d    <= start_s;
            lfsr       <= lfsr_next(lfsr);
        end
    end
    assign start_rise = start_s & ~start_d;

    assign tick = (state != IDLE) && (fcnt == FD_W'(FRAME_DIV - 1));

    // Divider restarts on every entry to SPIN_UP so the first speed step is a full frame away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fcnt <= '0;
        else if (state == IDLE || tick || (state_nxt == SPIN_UP && state != SPIN_UP))
            fcnt <= '0;
        else
            fcnt <= fcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign enter_stop = (state == SPIN_DOWN) && !start_s && tick && (speed == 8'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_rise) state_nxt = SPIN_UP;
            SPIN_UP:   if (!start_s)   state_nxt = SPIN_DOWN;
            SPIN_DOWN: begin
                if (start_s)         state_nxt = SPIN_UP;
                else if (enter_stop) state_nxt = STOPPING;
            end
            STOPPING: begin
                if (start_rise)                   state_nxt = SPIN_UP;
                else if (&(stopped | stop_req))   state_nxt = EVAL;
            end
            EVAL:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        seed     = 1'b0;
        clr_stop = 1'b0;
        spd_inc  = 1'b0;
        spd_dec  = 1'b0;
        do_eval  = 1'b0;
        case (state)
            IDLE:      seed     = start_rise;
            SPIN_UP:   spd_inc  = tick && (speed < 8'(MAX_SPEED));
            SPIN_DOWN: spd_dec  = tick && (speed > 8'd1);
            STOPPING:  clr_stop = start_rise;
            EVAL:      do_eval  = 1'b1;
            default:   ;
        endcase
    end

    assign scnt_inc = scnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            scnt <= '0;
        else if (enter_stop)
            scnt <= '0;
        else if (state == STOPPING && tick)
            scnt <= scnt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed   <= '0;
            won     <= 1'b0;
            pair    <= 1'b0;
            win_cnt <= '0;
        end else begin
            if (seed)         speed <= 8'd1;
            else if (do_eval) speed <= 8'd0;
            else if (spd_inc) speed <= speed + 8'd1;
            else if (spd_dec) speed <= speed - 8'd1;

            if (seed) begin
                won  <= 1'b0;
                pair <= 1'b0;
            end else if (do_eval) begin
                won  <= all_eq;
                pair <= !all_eq && any_pair;
                if (all_eq && win_cnt != {WINCNT_W{1'b1}})
                    win_cnt <= win_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        if (i == 0) begin : g_first
            assign stop_req[i] = enter_stop;
        end else begin : g_rest
            assign stop_req[i] = (state == STOPPING) && tick && !start_rise &&
                                 (scnt_inc == SC_W'(i * STAGGER));
        end

        slot_reel #(.MAX_SPEED(MAX_SPEED)) u_reel (
            .clk        (clk),
            .rst_n      (rst_n),
            .seed       (seed),
            .seed_digit (bcd_mod10(lfsr[4*(i%4) +: 4])),
            .tick       (tick),
            .speed      (speed),
            .stop       (stop_req[i]),
            .clr_stop   (clr_stop),
            .digit      (dig[i]),
            .stopped    (stopped[i])
        );
    end

    always_comb begin
        all_eq   = 1'b1;
        any_pair = 1'b0;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (dig[i] != dig[0])   all_eq   = 1'b0;
            if (dig[i] == dig[i-1]) any_pair = 1'b1;
        end
    end

    assign digits = dig;
    assign pause  = (state == IDLE);

endmodule
